// File: rtl/bus_read_serializer_pkg.sv
// Shared constants for the bus read serializer: FSM state codes and bit-cell timing.
package bus_read_serializer_pkg;

    localparam logic [2:0] RST0 = 3'd0;
    localparam logic [2:0] RST1 = 3'd1;
    localparam logic [2:0] RST2 = 3'd2;
    localparam logic [2:0] RST3 = 3'd3;
    localparam logic [2:0] RST4 = 3'd4;

    localparam int TIMER_W        = 5;
    localparam int BIT_PERIOD     = 28;
    localparam int CLK_PW         = 6;
    localparam int DATA_LO        = 14;
    localparam int DATA_HI        = 19;
    localparam int PREAMBLE_BITS  = 120;
    localparam int POSTAMBLE_BITS = 16;

    function automatic logic in_data_window(input logic [TIMER_W-1:0] t);
        return (t >= TIMER_W'(DATA_LO)) && (t <= TIMER_W'(DATA_HI));
    endfunction

endpackage

// File: rtl/bus_read_serializer_bit_timer.sv
// Bit-cell timer: counts 0..BIT_PERIOD-1 while enabled and shapes the read clock pulse.
module busread_bit_timer
    import bus_read_serializer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [TIMER_W-1:0] timer,
    output logic               cell_start,
    output logic               clk_pulse
);

    assign cell_start = enable && (timer == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            timer     <= '0;
            clk_pulse <= 1'b0;
        end else if (!enable) begin
            timer     <= '0;
            clk_pulse <= 1'b0;
        end else begin
            timer     <= (timer == TIMER_W'(BIT_PERIOD - 1)) ? '0 : timer + 1'b1;
            clk_pulse <= (timer < TIMER_W'(CLK_PW));
        end
    end

endmodule

// File: rtl/bus_read_serializer.sv
// Serializes DRAM sector words onto the active-low read clock/data bus with preamble, sync and postamble.
//   state | meaning
//   RST0  | idle, bus high
//   RST1  | preamble, 120 zero cells
//   RST2  | sync, one 1 cell
//   RST3  | data words, 16 cells each, LSB first
//   RST4  | postamble, 16 zero cells
module bus_read_serializer
    import bus_read_serializer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        Selected_Ready,
    input  logic        write_selected_ready,
    input  logic        clkenbl_sector,
    input  logic [15:0] data_length,
    input  logic [15:0] dram_readdata,
    input  logic        dram_readdata_valid,
    output logic        load_address_busread,
    output logic        dram_read_enbl_busread,
    output logic        BUS_RD_CLK_L,
    output logic        BUS_RD_DATA_L,
    output logic        read_underrun,
    output logic [7:0]  brs_debug
);

    logic [2:0]         state;
    logic [TIMER_W-1:0] timer;
    logic               cell_start;
    logic               clk_pulse;
    logic [6:0]         cell_cnt;
    logic [11:0]        word_cnt;
    logic [15:0]        shift_reg;
    logic [15:0]        buf_data;
    logic               buf_valid;
    logic               req_outstanding;
    logic               run;
    logic               start;
    logic               cell_end;
    logic               load_pt;
    logic               issue_req;
    logic               strobe_ok;
    logic               cur_bit;
    logic               unused_len_bits;

    assign unused_len_bits = ^data_length[3:0];

    // Any loss of drive readiness or a write in progress drops the transmission at once.
    assign run       = (state != RST0) && Selected_Ready && !write_selected_ready;
    assign start     = (state == RST0) && clkenbl_sector && Selected_Ready && !write_selected_ready;
    assign cell_end  = run && (timer == TIMER_W'(BIT_PERIOD - 1));
    assign load_pt   = run && (state == RST3) && cell_start && (cell_cnt == '0);
    assign issue_req = run && (((state == RST1) && load_address_busread) ||
                               (load_pt && (word_cnt != '0)));
    assign strobe_ok = dram_readdata_valid && req_outstanding && !start;

    assign brs_debug    = {5'd0, state};
    assign BUS_RD_CLK_L = ~clk_pulse;

    busread_bit_timer u_bit_timer (
        .clock      (clock),
        .reset      (reset),
        .enable     (run),
        .timer      (timer),
        .cell_start (cell_start),
        .clk_pulse  (clk_pulse)
    );

    always_comb begin
        cur_bit = 1'b0;
        case (state)
            RST2:    cur_bit = 1'b1;
            RST3:    cur_bit = shift_reg[0];
            default: cur_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RST0;
            cell_cnt <= '0;
            word_cnt <= '0;
        end else if (start) begin
            state    <= RST1;
            cell_cnt <= '0;
            word_cnt <= data_length[15:4];
        end else if (!run) begin
            state    <= RST0;
            cell_cnt <= '0;
        end else if (cell_end) begin
            case (state)
                RST1: begin
                    if (cell_cnt == 7'(PREAMBLE_BITS - 1)) begin
                        state    <= RST2;
                        cell_cnt <= '0;
                    end else begin
                        cell_cnt <= cell_cnt + 7'd1;
                    end
                end
                RST2: begin
                    state    <= RST3;
                    cell_cnt <= '0;
                end
                RST3: begin
                    if (cell_cnt == 7'd15) begin
                        cell_cnt <= '0;
                        if (word_cnt == '0) state <= RST4;
                        else                word_cnt <= word_cnt - 12'd1;
                    end else begin
                        cell_cnt <= cell_cnt + 7'd1;
                    end
                end
                RST4: begin
                    if (cell_cnt == 7'(POSTAMBLE_BITS - 1)) begin
                        state    <= RST0;
                        cell_cnt <= '0;
                    end else begin
                        cell_cnt <= cell_cnt + 7'd1;
                    end
                end
                default: state <= RST0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg       <= '0;
            buf_data        <= '0;
            buf_valid       <= 1'b0;
            req_outstanding <= 1'b0;
            read_underrun   <= 1'b0;
        end else begin
            if (start) begin
                read_underrun <= 1'b0;
                buf_valid     <= 1'b0;
            end else if (load_pt) begin
                buf_valid <= 1'b0;
                if (buf_valid) begin
                    shift_reg <= buf_data;
                end else begin
                    shift_reg     <= '0;
                    read_underrun <= 1'b1;
                end
            end else if (cell_end) begin
                shift_reg <= shift_reg >> 1;
            end
            // A late word landing on the load cycle still fills the buffer for the next word.
            if (strobe_ok) begin
                buf_data  <= dram_readdata;
                buf_valid <= 1'b1;
            end
            if (start)          req_outstanding <= 1'b0;
            else if (issue_req) req_outstanding <= 1'b1;
            else if (strobe_ok) req_outstanding <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            load_address_busread   <= 1'b0;
            dram_read_enbl_busread <= 1'b0;
            BUS_RD_DATA_L          <= 1'b1;
        end else begin
            load_address_busread   <= start;
            dram_read_enbl_busread <= issue_req;
            BUS_RD_DATA_L          <= !(run && cur_bit && in_data_window(timer));
        end
    end

endmodule

// File: tb/tb_bus_read_serializer.sv
// Directed bench: decodes the read bus into cells and checks frames, underrun, abort and reset.
module tb_bus_read_serializer;
    import bus_read_serializer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Selected_Ready = 1'b1;
    logic        write_selected_ready = 1'b0;
    logic        clkenbl_sector = 1'b0;
    logic [15:0] data_length = 16'h00B0;
    logic [15:0] dram_readdata = 16'h0000;
    logic        dram_readdata_valid = 1'b0;
    logic        load_address_busread;
    logic        dram_read_enbl_busread;
    logic        BUS_RD_CLK_L;
    logic        BUS_RD_DATA_L;
    logic        read_underrun;
    logic [7:0]  brs_debug;

    localparam int NWORDS = 12;
    localparam int FRAME_CELLS = 120 + 1 + 16 * NWORDS + 16;

    bus_read_serializer dut (
        .clock                  (clock),
        .reset                  (reset),
        .Selected_Ready         (Selected_Ready),
        .write_selected_ready   (write_selected_ready),
        .clkenbl_sector         (clkenbl_sector),
        .data_length            (data_length),
        .dram_readdata          (dram_readdata),
        .dram_readdata_valid    (dram_readdata_valid),
        .load_address_busread   (load_address_busread),
        .dram_read_enbl_busread (dram_read_enbl_busread),
        .BUS_RD_CLK_L           (BUS_RD_CLK_L),
        .BUS_RD_DATA_L          (BUS_RD_DATA_L),
        .read_underrun          (read_underrun),
        .brs_debug              (brs_debug)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] data_of(input int i);
        return (i == 3) ? 16'h8001 : 16'(i);
    endfunction

    // Bus monitor and DRAM responder
    bit   cells [0:4095];
    int   ncells = 0, req_count = 0, la_count = 0;
    int   clk_pw_bad = 0, data_pw_bad = 0, align_bad = 0;
    int   since_clk = 0, clk_run = 0, data_run = 0;
    int   withhold_idx = -1, fidx = 0, pend_cnt = 0, pend_idx = 0;
    logic prev_clk_l = 1'b1, prev_data_l = 1'b1;

    always @(negedge clock) begin
        dram_readdata_valid = 1'b0;
        if (load_address_busread === 1'b1) begin
            la_count++;
            fidx = 0;
        end
        if (dram_read_enbl_busread === 1'b1) begin
            req_count++;
            if (fidx != withhold_idx) begin
                pend_cnt = 3;
                pend_idx = fidx;
            end
            fidx++;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                dram_readdata_valid = 1'b1;
                dram_readdata = data_of(pend_idx);
            end
        end

        since_clk++;
        if (prev_clk_l === 1'b1 && BUS_RD_CLK_L === 1'b0) begin
            if (ncells < 4096) cells[ncells] = 1'b0;
            ncells++;
            since_clk = 0;
            clk_run = 1;
        end else if (BUS_RD_CLK_L === 1'b0) begin
            clk_run++;
        end
        if (prev_clk_l === 1'b0 && BUS_RD_CLK_L === 1'b1 && clk_run != CLK_PW) clk_pw_bad++;

        if (prev_data_l === 1'b1 && BUS_RD_DATA_L === 1'b0) begin
            if (ncells > 0 && ncells <= 4096) cells[ncells-1] = 1'b1;
            if (since_clk != 14) align_bad++;
            data_run = 1;
        end else if (BUS_RD_DATA_L === 1'b0) begin
            data_run++;
        end
        if (prev_data_l === 1'b0 && BUS_RD_DATA_L === 1'b1 && data_run != 6) data_pw_bad++;

        prev_clk_l  = BUS_RD_CLK_L;
        prev_data_l = BUS_RD_DATA_L;
    end

    int cb, rb, lb, pb, db, ab;

    task automatic snapshot();
        cb = ncells; rb = req_count; lb = la_count;
        pb = clk_pw_bad; db = data_pw_bad; ab = align_bad;
    endtask

    task automatic pulse_sector();
        @(negedge clock) clkenbl_sector = 1'b1;
        @(negedge clock) clkenbl_sector = 1'b0;
    endtask

    task automatic wait_cells(input int target, input int budget);
        int n = 0;
        while (ncells < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("reach_cells", 32'(ncells >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (brs_debug != 8'd0 && n < budget);
        @(negedge clock);
        chk("idle", brs_debug, 0);
    endtask

    task automatic check_frame(input int uw);
        int ones;
        logic [15:0] word, exp_word;
        chk("frame_cells", ncells - cb, FRAME_CELLS);
        ones = 0;
        for (int i = 0; i < 120; i++) ones += cells[cb+i];
        chk("preamble_zero", ones, 0);
        chk("sync_bit", cells[cb+120], 1);
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < 16; b++) word[b] = cells[cb+121+16*w+b];
            exp_word = (w == uw) ? 16'h0000 : data_of(w);
            chk($sformatf("word%0d", w), word, exp_word);
        end
        ones = 0;
        for (int b = 0; b < 16; b++) ones += cells[cb+121+48+b];
        chk("w3_pulses", ones, 2);
        ones = 0;
        for (int i = 0; i < 16; i++) ones += cells[cb+121+16*NWORDS+i];
        chk("postamble_zero", ones, 0);
        chk("req_count", req_count - rb, NWORDS);
        chk("la_count", la_count - lb, 1);
        chk("clk_pw", clk_pw_bad - pb, 0);
        chk("data_pw", data_pw_bad - db, 0);
        chk("data_align", align_bad - ab, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_state", brs_debug, 0);
        chk("rst_clk_l", BUS_RD_CLK_L, 1);
        chk("rst_data_l", BUS_RD_DATA_L, 1);
        chk("rst_la", load_address_busread, 0);
        chk("rst_rd_en", dram_read_enbl_busread, 0);
        chk("rst_underrun", read_underrun, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Normal frame, stray sector pulse during data
        snapshot();
        pulse_sector();
        chk("start_la", load_address_busread, 1);
        chk("start_state", brs_debug, 1);
        @(negedge clock);
        chk("prefetch_req", dram_read_enbl_busread, 1);
        chk("la_one_shot", load_address_busread, 0);
        @(negedge clock);
        chk("prefetch_one_shot", dram_read_enbl_busread, 0);
        wait_cells(cb + 121 + 32, 6000);
        pulse_sector();
        chk("ignore_start", brs_debug, 3);
        wait_idle(12000);
        check_frame(-1);
        chk("no_underrun", read_underrun, 0);

        // Word 5 withheld
        withhold_idx = 5;
        snapshot();
        pulse_sector();
        wait_idle(12000);
        check_frame(5);
        chk("underrun_set", read_underrun, 1);
        withhold_idx = -1;
        repeat (10) @(negedge clock);
        chk("underrun_sticky", read_underrun, 1);

        // Write during word 10
        snapshot();
        pulse_sector();
        chk("underrun_clear", read_underrun, 0);
        wait_cells(cb + 284, 10000);
        @(negedge clock) write_selected_ready = 1'b1;
        @(negedge clock);
        chk("abort_state", brs_debug, 0);
        chk("abort_clk_l", BUS_RD_CLK_L, 1);
        chk("abort_data_l", BUS_RD_DATA_L, 1);
        write_selected_ready = 1'b0;
        repeat (1000) @(negedge clock);
        chk("abort_req", req_count - rb, 12);
        chk("abort_cells", ncells - cb, 284);
        chk("abort_state_hold", brs_debug, 0);

        // Reset at preamble cell 50
        snapshot();
        pulse_sector();
        wait_cells(cb + 50, 3000);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_state", brs_debug, 0);
        chk("mid_rst_clk_l", BUS_RD_CLK_L, 1);
        chk("mid_rst_data_l", BUS_RD_DATA_L, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_rd_en", dram_read_enbl_busread, 0);
        chk("post_rst_la", load_address_busread, 0);
        chk("post_rst_state", brs_debug, 0);
        repeat (200) @(negedge clock);
        chk("post_rst_req", req_count - rb, 1);
        chk("post_rst_cells", ncells - cb, 50);
        chk("post_rst_underrun", read_underrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
